// File: rtl/uart_tx_wb.sv
// uart_tx_wb: Wishbone-slave UART transmitter with a byte TX FIFO.
// Register map (adr_i[3:2]): 0 DATA (W, push), 1 STAT (R), 2 CTRL (R/W), 3 DIV (R/W).
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after data bit 7.
// Without it, frames are 8N1 only.
module uart_tx_wb #(
    parameter int          pClkFreq  = 25000000,
    parameter int          pBaud     = 115200,
    parameter logic [27:0] pAddr     = 28'hFFDC00A,
    parameter int          pFifoLog2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        txd_o,
    output logic        irq_o
);

    localparam int          DEPTH   = 2 ** pFifoLog2;
    localparam int          CW      = pFifoLog2 + 1;
    localparam logic [15:0] RST_DIV = 16'(pClkFreq / pBaud - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic       PAR_EN    = 1'b1;
`else
    localparam logic       PAR_EN    = 1'b0;
`endif

    // Bus decode
    logic       cs;
    logic       acc;
    logic [1:0] sel;
    logic       wr_data;
    logic       rd_stat;
    logic       wr_ctrl;
    logic       wr_div;

    // FIFO
    logic [7:0]           mem [DEPTH];
    logic [pFifoLog2-1:0] wr_ptr;
    logic [pFifoLog2-1:0] rd_ptr;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 ovf;

    // Registers and engine
    logic        irq_en;
    logic [15:0] div;
    logic [2:0]  state;
    logic [2:0]  idx;
    logic [15:0] baud_cnt;
    logic        bit_end;
    logic        busy;
    logic [7:0]  tx_byte;
    logic [31:0] stat;

    // Address bits below the word and the upper write-data half are never used.
    logic unused_bits;
    assign unused_bits = ^{adr_i[1:0], dat_i[31:16]};

    assign cs  = cyc_i & stb_i & (adr_i[31:4] == pAddr);
    // Side effects fire only on the first cycle of an access, before ack rises.
    assign acc = cs & ~ack_o;
    assign sel = adr_i[3:2];

    assign wr_data = acc &  we_i & (sel == 2'd0);
    assign rd_stat = acc & ~we_i & (sel == 2'd1);
    assign wr_ctrl = acc &  we_i & (sel == 2'd2);
    assign wr_div  = acc &  we_i & (sel == 2'd3);

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign bit_end = (baud_cnt == 16'd0);
    assign busy    = (state != ST_IDLE);

    // Engine takes a byte when idle, or at the end of a stop bit for gap-free streaming.
    assign pop  = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
    // A push into a full FIFO still fits if the engine pops in the same cycle.
    assign push = wr_data & (~full | pop);

    assign stat = {22'd0, PAR_EN, 5'(count), ovf, empty, full, busy};

    // Registered acknowledge: follows cs one clock later.
    always_ff @(posedge clk) begin
        if (rst) ack_o <= 1'b0;
        else     ack_o <= cs;
    end

    // Combinational read mux; drives zero when not selected so the bridge can OR buses.
    always_comb begin
        dat_o = 32'h0;
        if (cs) begin
            case (sel)
                2'd1:    dat_o = stat;
                2'd2:    dat_o = {31'd0, irq_en};
                2'd3:    dat_o = {16'd0, div};
                default: dat_o = 32'h0;
            endcase
        end
    end

    // Control registers: interrupt enable and baud divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            div    <= RST_DIV;
        end else begin
            if (wr_ctrl) irq_en <= dat_i[0];
            if (wr_div)  div    <= dat_i[15:0];
        end
    end

    // FIFO storage; data path only, not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dat_i[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow (cleared by a STAT read).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_data & full & ~pop) ovf <= 1'b1;
            else if (rd_stat)          ovf <= 1'b0;
        end
    end

    // Latch the byte being sent when the engine pops it.
    always_ff @(posedge clk) begin
        if (pop) tx_byte <= mem[rd_ptr];
    end

    // Bit-serial engine: state, bit index and baud counter (reloaded at each bit start).
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= 3'd0;
            baud_cnt <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state    <= ST_START;
                        baud_cnt <= div;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state    <= ST_DATA;
                        idx      <= 3'd0;
                        baud_cnt <= div;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= div;
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state    <= ST_STOP;
                        baud_cnt <= div;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (!empty) begin
                            state    <= ST_START;
                            baud_cnt <= div;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered serial output, one clock behind the state, so the line is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd_o <= 1'b1;
        end else begin
            case (state)
                ST_START:  txd_o <= 1'b0;
                ST_DATA:   txd_o <= tx_byte[idx];
`ifdef UART_TX_PARITY_EN
                ST_PARITY: txd_o <= ^tx_byte;
`endif
                default:   txd_o <= 1'b1;
            endcase
        end
    end

    // FIFO-empty interrupt, registered so it rises as the last stop bit leaves the line.
    always_ff @(posedge clk) begin
        if (rst) irq_o <= 1'b0;
        else     irq_o <= irq_en & empty & ~busy;
    end

endmodule

// File: tb/tb_uart_tx_wb.sv
// tb_uart_tx_wb: self-checking bench for uart_tx_wb (register table, serial frame receiver,
// FIFO overflow, reset abort, interrupt, randomized byte streams).
module tb_uart_tx_wb;

    localparam logic [31:0] BASE = 32'hFFDC00A0;
`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PARBIT = 32'h200;
    localparam int          NBITS  = 11;
`else
    localparam logic [31:0] PARBIT = 32'h0;
    localparam int          NBITS  = 10;
`endif
    localparam logic [31:0] S_IDLE = 32'h4 | PARBIT;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic [31:0] rdat;
    logic        txd;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    uart_tx_wb dut (
        .clk   (clk),
        .rst   (rst),
        .cyc_i (cyc),
        .stb_i (stb),
        .we_i  (we),
        .adr_i (adr),
        .dat_i (dat),
        .ack_o (ack),
        .dat_o (rdat),
        .txd_o (txd),
        .irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  sel;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Expected line levels for one frame, bit 0 first: start, data LSB first, [parity], stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    task automatic wb_write(input logic [1:0] sel, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE | {28'h0, sel, 2'b00}; dat = d;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_read(input logic [1:0] sel, output logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | {28'h0, sel, 2'b00};
        #1 d = rdat;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_ack", {31'd0, ack}, 32'd0);
        rst = 1'b0;
    endtask

    // Waits for a start bit, then checks every clock of the frame against the expected bits.
    // Returns on the last clock of the stop bit.
    task automatic rx_frame(input int p, input logic [7:0] exp_b, output logic irq_seen);
        int          t;
        logic        bad;
        logic [7:0]  got;
        logic [10:0] bits;
        irq_seen = 1'b0;
        bad = 1'b0;
        got = 8'h0;
        t = 0;
        while (txd !== 1'b0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (txd !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL rx_start: no start bit, line=%b required 0 (byte %h)", txd, exp_b);
            return;
        end
        bits = frame_bits(exp_b);
        for (int k = 0; k < NBITS; k++) begin
            for (int j = 0; j < p; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                if (irq === 1'b1) irq_seen = 1'b1;
                if (j == 0 && k >= 1 && k <= 8) got[k-1] = txd;
                if (txd !== bits[k]) bad = 1'b1;
            end
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rx_frame: got data %h required %h (bit level or timing wrong)", got, exp_b);
        end
    endtask

    task automatic idle_chk(input int n, input string name);
        logic bad;
        bad = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (txd !== 1'b1) bad = 1'b1;
        end
        chk(name, {31'd0, bad}, 32'd0);
    endtask

    vec_t        vecs[12];
    logic [31:0] r;
    logic        irqs;
    logic [7:0]  rbuf[16];
    int          t;
    int          rdiv;
    int          rn;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; dat = 32'h0;
        vecs[0]  = '{2'd1, 1'b0, 32'h0,         S_IDLE};
        vecs[1]  = '{2'd3, 1'b0, 32'h0,         32'd216};
        vecs[2]  = '{2'd2, 1'b0, 32'h0,         32'h0};
        vecs[3]  = '{2'd0, 1'b0, 32'h0,         32'h0};
        vecs[4]  = '{2'd3, 1'b1, 32'hABCD_1234, 32'h0};
        vecs[5]  = '{2'd3, 1'b0, 32'h0,         32'h0000_1234};
        vecs[6]  = '{2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{2'd2, 1'b0, 32'h0,         32'h1};
        vecs[8]  = '{2'd2, 1'b1, 32'h0000_0002, 32'h0};
        vecs[9]  = '{2'd2, 1'b0, 32'h0,         32'h0};
        vecs[10] = '{2'd3, 1'b1, 32'h0000_0003, 32'h0};
        vecs[11] = '{2'd1, 1'b0, 32'h0,         S_IDLE};

        // Reset state and register table
        repeat (2) @(negedge clk);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) wb_write(vecs[i].sel, vecs[i].wdata);
            else begin
                wb_read(vecs[i].sel, r);
                chk($sformatf("reg_vec%0d", i), r, vecs[i].exp);
            end
        end

        // Address miss: no ack, zero read data
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0004;
        #1 chk("miss_dat", rdat, 32'h0);
        @(negedge clk);
        chk("miss_ack", {31'd0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);

        // Held write: ack timing, exactly one push
        fork
            begin
                cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat = 32'h5A;
                #1 chk("held_ack0", {31'd0, ack}, 32'd0);
                @(negedge clk); chk("held_ack1", {31'd0, ack}, 32'd1);
                @(negedge clk); chk("held_ack2", {31'd0, ack}, 32'd1);
                @(negedge clk); chk("held_ack3", {31'd0, ack}, 32'd1);
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
                @(negedge clk); chk("held_ack_drop", {31'd0, ack}, 32'd0);
            end
            rx_frame(4, 8'h5A, irqs);
        join
        idle_chk(60, "held_single_push");

        // Single byte A5 at DIV=3, start latency two clocks after the push
        wb_write(2'd0, 32'hA5);
        chk("lat_txd_high", {31'd0, txd}, 32'd1);
        @(negedge clk);
        chk("lat_txd_start", {31'd0, txd}, 32'd0);
        rx_frame(4, 8'hA5, irqs);
        wb_read(2'd1, r);
        chk("a5_stat_after", r, S_IDLE);

        // Two bytes: no idle gap between stop and next start
        fork
            begin
                wb_write(2'd0, 32'h3C);
                wb_write(2'd0, 32'hC3);
            end
            begin
                rx_frame(4, 8'h3C, irqs);
                @(negedge clk);
                chk("b2b_no_gap", {31'd0, txd}, 32'd0);
                rx_frame(4, 8'hC3, irqs);
            end
        join

        // Interrupt behaviour
        @(negedge clk);
        wb_write(2'd2, 32'h1);
        chk("irq_idle_high", {31'd0, irq}, 32'd1);
        fork
            wb_write(2'd0, 32'h81);
            rx_frame(4, 8'h81, irqs);
        join
        chk("irq_low_in_frame", {31'd0, irqs}, 32'd0);
        @(negedge clk);
        chk("irq_after_stop", {31'd0, irq}, 32'd1);
        wb_write(2'd2, 32'h0);
        chk("irq_disabled", {31'd0, irq}, 32'd0);

        // Fill, overflow and clear-on-read
        fork
            begin
                for (int k = 1; k <= 17; k++) wb_write(2'd0, 32'((k * 37 + 5) & 8'hFF));
                wb_read(2'd1, r);
                chk("fill_stat", r, 32'h103 | PARBIT);
                wb_write(2'd0, 32'hEE);
                wb_read(2'd1, r);
                chk("ovf_stat", r, 32'h10B | PARBIT);
                wb_read(2'd1, r);
                chk("ovf_cleared", {31'd0, r[3]}, 32'd0);
            end
            begin
                for (int k = 1; k <= 17; k++) rx_frame(4, 8'((k * 37 + 5) & 8'hFF), irqs);
            end
        join
        idle_chk(60, "dropped_byte_not_sent");
        wb_read(2'd1, r);
        chk("fill_stat_end", r, S_IDLE);

        // Reset in the middle of a frame with another byte queued
        do_reset();
        wb_write(2'd3, 32'd3);
        wb_write(2'd0, 32'hF0);
        wb_write(2'd0, 32'h0F);
        t = 0;
        while (txd !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("abort_start_seen", {31'd0, txd}, 32'd0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_txd", {31'd0, txd}, 32'd1);
        chk("abort_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        wb_read(2'd1, r);
        chk("abort_stat", r, S_IDLE);
        wb_read(2'd3, r);
        chk("abort_div", r, 32'd216);
        idle_chk(120, "abort_no_frames");

`ifdef UART_TX_PARITY_EN
        // Parity frame: 8'h07 has an odd number of ones, so the parity bit is 1
        wb_write(2'd3, 32'd3);
        fork
            wb_write(2'd0, 32'h07);
            rx_frame(4, 8'h07, irqs);
        join
        @(negedge clk);
        wb_read(2'd1, r);
        chk("parity_stat", r, S_IDLE);
`endif

        // Randomized byte streams against the frame model
        for (int it = 0; it < 6; it++) begin
            rdiv = $urandom_range(0, 5);
            rn = $urandom_range(1, 10);
            for (int i = 0; i < rn; i++) rbuf[i] = 8'($urandom);
            wb_write(2'd3, 32'(rdiv));
            fork
                begin
                    for (int i = 0; i < rn; i++) begin
                        wb_write(2'd0, {24'd0, rbuf[i]});
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                    end
                end
                begin
                    for (int i = 0; i < rn; i++) rx_frame(rdiv + 1, rbuf[i], irqs);
                end
            join
            @(negedge clk);
            wb_read(2'd1, r);
            chk($sformatf("rand%0d_stat", it), r, S_IDLE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
